// File: rtl/arc_mem_arb_pkg.sv
// Shared types and default sizes for the IF/MEM unified-memory arbiter.
// The optional busy-state watchdog is enabled with MEM_ARB_TIMEOUT_EN.
package arc_mem_arb_pkg;

  localparam int unsigned DEF_AW             = 32;
  localparam int unsigned DEF_DW             = 32;
  localparam int unsigned DEF_MAX_DM_STREAK  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  // Wide enough for the largest legal streak limit (15).
  localparam int unsigned STREAK_W           = 4;

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    DONE
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for mem_port_arbiter. Only compiled and used when
// MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
  import arc_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_timeout,
  output logic o_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Memory answering on the limit cycle still wins over the timeout.
  assign o_timeout = i_busy && !i_ready && (cnt_q == LIMIT);

  // Count busy cycles (cleared whenever not busy) and latch the sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      o_err <= 1'b0;
    end else begin
      if (!i_busy) begin
        cnt_q <= '0;
      end else if (cnt_q != LIMIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (o_timeout) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the IF and MEM stages,
// sequences the memory handshake and drives the pipeline stall.
// Define MEM_ARB_TIMEOUT_EN to add the busy-state watchdog and sticky o_err.
module mem_port_arbiter
  import arc_mem_arb_pkg::*;
#(
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned DW             = DEF_DW,
  parameter int unsigned MAX_DM_STREAK  = DEF_MAX_DM_STREAK,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_dm_valid,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_stall,
  output logic          o_err
);

  if (MAX_DM_STREAK < 1 || MAX_DM_STREAK > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_DM_STREAK must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          state_q, state_d;
  grant_t              gnt_q, gnt_d;
  logic                grant_en;
  logic [STREAK_W-1:0] streak_q;
  logic                busy;
  logic                timeout;
  logic                complete;

  assign busy     = (state_q == IF_BUSY) || (state_q == DM_BUSY);
  assign complete = busy && (i_mem_ready || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_busy    (busy),
    .i_ready   (i_mem_ready),
    .o_timeout (timeout),
    .o_err     (o_err)
  );
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  // Next-state, grant selection and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    grant_en   = 1'b0;
    o_mem_req  = 1'b0;
    o_if_valid = 1'b0;
    o_dm_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_dm_req && !(i_if_req && (streak_q == STREAK_MAX))) begin
          state_d  = DM_BUSY;
          gnt_d    = GNT_DM;
          grant_en = 1'b1;
        end else if (i_if_req) begin
          state_d  = IF_BUSY;
          gnt_d    = GNT_IF;
          grant_en = 1'b1;
        end
      end
      IF_BUSY, DM_BUSY: begin
        o_mem_req = 1'b1;
        if (complete) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_if_valid = (gnt_q == GNT_IF);
        o_dm_valid = (gnt_q == GNT_DM);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_IF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Latch the winner's fields, track the DM streak and capture read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      streak_q    <= '0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
    end else begin
      if (grant_en) begin
        if (gnt_d == GNT_DM) begin
          o_mem_we    <= i_dm_we;
          o_mem_addr  <= i_dm_addr;
          o_mem_wdata <= i_dm_wdata;
          if (i_if_req) begin
            streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_q <= '0;
          end
        end else begin
          o_mem_we    <= 1'b0;
          o_mem_addr  <= i_if_addr;
          o_mem_wdata <= '0;
          streak_q    <= '0;
        end
      end
      // A timed-out access (no ready) returns zero data.
      if (complete) begin
        if (gnt_q == GNT_IF) begin
          o_if_rdata <= i_mem_ready ? i_mem_rdata : '0;
        end else begin
          o_dm_rdata <= (o_mem_we || !i_mem_ready) ? '0 : i_mem_rdata;
        end
      end
    end
  end

  assign o_stall = (i_if_req & ~o_if_valid) | (i_dm_req & ~o_dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed handshake cases followed
// by randomized mixed traffic against a word-level memory/arbitration model.
// Timeout case is exercised when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXS = 2;
  localparam int unsigned TO   = 8;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          i_dm_req;
  logic          i_dm_we;
  logic [AW-1:0] i_dm_addr;
  logic [DW-1:0] i_dm_wdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready;
  logic [DW-1:0] i_mem_rdata;
  logic          o_if_valid;
  logic [DW-1:0] o_if_rdata;
  logic          o_dm_valid;
  logic [DW-1:0] o_dm_rdata;
  logic          o_stall;
  logic          o_err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW             (AW),
    .DW             (DW),
    .MAX_DM_STREAK  (MAXS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .i_dm_req    (i_dm_req),
    .i_dm_we     (i_dm_we),
    .i_dm_addr   (i_dm_addr),
    .i_dm_wdata  (i_dm_wdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .o_if_valid  (o_if_valid),
    .o_if_rdata  (o_if_rdata),
    .o_dm_valid  (o_dm_valid),
    .o_dm_rdata  (o_dm_rdata),
    .o_stall     (o_stall),
    .o_err       (o_err)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, o_mem_req, 0);
    chk({tag, "_mem_we"}, o_mem_we, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_if_valid"}, o_if_valid, 0);
    chk({tag, "_if_rdata"}, o_if_rdata, 0);
    chk({tag, "_dm_valid"}, o_dm_valid, 0);
    chk({tag, "_dm_rdata"}, o_dm_rdata, 0);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  task automatic idle_inputs();
    i_if_req    = 1'b0;
    i_if_addr   = '0;
    i_dm_req    = 1'b0;
    i_dm_we     = 1'b0;
    i_dm_addr   = '0;
    i_dm_wdata  = '0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idle_inputs();
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Bounded wait for the memory request; an expired budget is a failure.
  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!o_mem_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, o_mem_req, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  // Randomized-phase model state
  logic [DW-1:0] ref_mem  [16];
  logic [DW-1:0] resp_mem [16];
  logic          if_pend, dm_pend, exp_dm;
  int unsigned   streak;
  logic [DW-1:0] last_if, last_dm;
  logic [AW-1:0] exp_addr, obs_addr;
  int unsigned   idx, ridx, waits;
  bit            order [6];

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk_all_zero("reset");
    i_rst = 1'b0;
    step();

    // Ready while idle must not produce a completion.
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h0BAD_0BAD;
    step();
    i_mem_ready = 1'b0;
    chk("idle_rdy_ifv", o_if_valid, 0);
    chk("idle_rdy_dmv", o_dm_valid, 0);
    step();
    chk("idle_rdy_dmv2", o_dm_valid, 0);
    chk("idle_rdy_req", o_mem_req, 0);

    // Single fetch, zero wait.
    i_if_req  = 1'b1;
    i_if_addr = 32'h0000_0040;
    #1;
    chk("fetch_stall_c0", o_stall, 1);
    step();
    chk("fetch_req_c1", o_mem_req, 1);
    chk("fetch_addr_c1", o_mem_addr, 32'h40);
    chk("fetch_we_c1", o_mem_we, 0);
    chk("fetch_wdata_c1", o_mem_wdata, 0);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h2108_0001;
    step();
    i_mem_ready = 1'b0;
    chk("fetch_valid_c2", o_if_valid, 1);
    chk("fetch_rdata_c2", o_if_rdata, 32'h2108_0001);
    chk("fetch_stall_c2", o_stall, 0);
    chk("fetch_req_c2", o_mem_req, 0);
    i_if_req = 1'b0;
    step();
    chk("fetch_valid_c3", o_if_valid, 0);
    chk("fetch_rdata_hold", o_if_rdata, 32'h2108_0001);

    // Load with three wait cycles.
    i_dm_req   = 1'b1;
    i_dm_addr  = 32'h100;
    i_dm_we    = 1'b0;
    i_dm_wdata = 32'h55;
    #1;
    chk("ld_stall_c0", o_stall, 1);
    chk("ld_req_c0", o_mem_req, 0);
    step();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("ld_req_c%0d", c), o_mem_req, 1);
      chk($sformatf("ld_addr_c%0d", c), o_mem_addr, 32'h100);
      chk($sformatf("ld_stall_c%0d", c), o_stall, 1);
      chk($sformatf("ld_valid_c%0d", c), o_dm_valid, 0);
      if (c == 4) begin
        i_mem_ready = 1'b1;
        i_mem_rdata = 32'hCAFE_0100;
      end
      step();
    end
    i_mem_ready = 1'b0;
    chk("ld_valid_c5", o_dm_valid, 1);
    chk("ld_rdata_c5", o_dm_rdata, 32'hCAFE_0100);
    chk("ld_stall_c5", o_stall, 0);
    chk("ld_ifvalid_c5", o_if_valid, 0);
    i_dm_req = 1'b0;
    step();
    chk("ld_valid_c6", o_dm_valid, 0);

    // Store: write fields presented, load data reads back as zero.
    i_dm_req   = 1'b1;
    i_dm_we    = 1'b1;
    i_dm_addr  = 32'h104;
    i_dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("st_we_c1", o_mem_we, 1);
    chk("st_wdata_c1", o_mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("st_we_c2", o_mem_we, 1);
    chk("st_wdata_c2", o_mem_wdata, 32'hDEAD_BEEF);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    step();
    i_mem_ready = 1'b0;
    chk("st_valid", o_dm_valid, 1);
    chk("st_rdata_zero", o_dm_rdata, 0);
    chk("st_if_rdata_hold", o_if_rdata, 32'h2108_0001);
    i_dm_req = 1'b0;
    i_dm_we  = 1'b0;
    step();

    // Reset in the middle of a busy data access.
    i_dm_req  = 1'b1;
    i_dm_addr = 32'h108;
    step();
    chk("rstmid_req_c1", o_mem_req, 1);
    step();
    i_rst    = 1'b1;
    i_dm_req = 1'b0;
    step();
    chk_all_zero("rstmid");
    i_rst = 1'b0;
    step();
    chk("rstmid_novalid", o_dm_valid, 0);
    i_dm_req  = 1'b1;
    i_dm_addr = 32'h10C;
    step();
    chk("rstmid_restart_req", o_mem_req, 1);
    chk("rstmid_restart_addr", o_mem_addr, 32'h10C);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h0000_0777;
    step();
    i_mem_ready = 1'b0;
    chk("rstmid_restart_valid", o_dm_valid, 1);
    chk("rstmid_restart_rdata", o_dm_rdata, 32'h777);
    i_dm_req = 1'b0;
    step();

    // Contention with both requests held: DM, DM, IF repeating.
    do_reset();
    order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    i_if_req  = 1'b1;
    i_if_addr = 32'h200;
    i_dm_req  = 1'b1;
    i_dm_addr = 32'h300;
    i_dm_we   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_req($sformatf("cont%0d", k));
      chk($sformatf("cont%0d_addr", k), o_mem_addr, order[k] ? 32'h300 : 32'h200);
      i_mem_ready = 1'b1;
      i_mem_rdata = 32'(k);
      step();
      i_mem_ready = 1'b0;
      chk($sformatf("cont%0d_dmv", k), o_dm_valid, order[k]);
      chk($sformatf("cont%0d_ifv", k), o_if_valid, !order[k]);
    end
    idle_inputs();
    step();

    // Randomized mixed traffic against a word-addressed memory model.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = $urandom;
      resp_mem[i] = ref_mem[i];
    end
    if_pend = 1'b0;
    dm_pend = 1'b0;
    streak  = 0;
    last_if = '0;
    last_dm = '0;
    for (int it = 0; it < 60; it++) begin
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend    = 1'b1;
        i_dm_req   = 1'b1;
        i_dm_we    = 1'($urandom_range(0, 1));
        i_dm_addr  = 32'($urandom_range(0, 15)) << 2;
        i_dm_wdata = $urandom;
      end
      if (!if_pend && ($urandom_range(0, 1) == 1 || !dm_pend)) begin
        if_pend   = 1'b1;
        i_if_req  = 1'b1;
        i_if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      exp_dm = dm_pend && !(if_pend && streak == MAXS);
      if (exp_dm && if_pend) streak = (streak + 1 > MAXS) ? MAXS : streak + 1;
      else streak = 0;
      exp_addr = exp_dm ? i_dm_addr : i_if_addr;
      idx      = int'(exp_addr[5:2]);

      wait_req($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_addr", it), o_mem_addr, exp_addr);
      chk($sformatf("rnd%0d_we", it), o_mem_we, exp_dm ? i_dm_we : 1'b0);
      chk($sformatf("rnd%0d_wdata", it), o_mem_wdata, exp_dm ? i_dm_wdata : 32'h0);
      obs_addr = o_mem_addr;
      ridx     = int'(obs_addr[5:2]);
      if (o_mem_we) resp_mem[ridx] = o_mem_wdata;
      waits = $urandom_range(0, 3);
      for (int w = 0; w < int'(waits); w++) begin
        i_mem_rdata = $urandom;
        step();
        chk($sformatf("rnd%0d_hold_req", it), o_mem_req, 1);
        chk($sformatf("rnd%0d_hold_stall", it), o_stall, 1);
      end
      i_mem_ready = 1'b1;
      i_mem_rdata = o_mem_we ? $urandom : resp_mem[ridx];
      step();
      i_mem_ready = 1'b0;
      i_mem_rdata = $urandom;

      if (exp_dm) begin
        if (i_dm_we) begin
          ref_mem[idx] = i_dm_wdata;
          last_dm      = '0;
        end else begin
          last_dm = ref_mem[idx];
        end
      end else begin
        last_if = ref_mem[idx];
      end
      chk($sformatf("rnd%0d_ifv", it), o_if_valid, !exp_dm);
      chk($sformatf("rnd%0d_dmv", it), o_dm_valid, exp_dm);
      chk($sformatf("rnd%0d_if_rdata", it), o_if_rdata, last_if);
      chk($sformatf("rnd%0d_dm_rdata", it), o_dm_rdata, last_dm);
      chk($sformatf("rnd%0d_stall", it), o_stall, exp_dm ? if_pend : dm_pend);
      if (exp_dm) begin
        dm_pend  = 1'b0;
        i_dm_req = 1'b0;
      end else begin
        if_pend  = 1'b0;
        i_if_req = 1'b0;
      end
    end
    idle_inputs();
    step();
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: completion forced after the busy limit.
    do_reset();
    i_dm_req    = 1'b1;
    i_dm_addr   = 32'h80;
    i_mem_rdata = 32'hFFFF_FFFF;
    step();
    for (int c = 1; c < 10; c++) begin
      chk($sformatf("to_req_c%0d", c), o_mem_req, 1);
      chk($sformatf("to_valid_c%0d", c), o_dm_valid, 0);
      step();
    end
    chk("to_valid_c10", o_dm_valid, 1);
    chk("to_rdata_c10", o_dm_rdata, 0);
    chk("to_err_c10", o_err, 1);
    i_dm_req = 1'b0;
    step();
    step();
    step();
    chk("to_err_sticky", o_err, 1);
    chk("to_valid_after", o_dm_valid, 0);
`else
    // Without the watchdog a silent memory just keeps the access pending.
    do_reset();
    i_dm_req    = 1'b1;
    i_dm_addr   = 32'h80;
    i_mem_rdata = 32'hFFFF_FFFF;
    step();
    for (int c = 1; c < 20; c++) begin
      chk($sformatf("noto_valid_c%0d", c), o_dm_valid, 0);
      step();
    end
    chk("noto_req", o_mem_req, 1);
    chk("noto_err", o_err, 0);
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h0000_ABCD;
    step();
    i_mem_ready = 1'b0;
    chk("noto_valid", o_dm_valid, 1);
    chk("noto_rdata", o_dm_rdata, 32'hABCD);
    chk("noto_err_after", o_err, 0);
    i_dm_req = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
